uart_arbiter: RTL and testbench
===============================

Name: uart_arbiter

Overview:
- Sequences and shares the AXI4-lite UART Lite slave between two requesters: the boot loader (RX byte stream) and the CPU output path (TX bytes).
- Polls STAT_REG, reads RX_FIFO, and writes TX_FIFO.
- Buffers TX bytes so the CPU does not stall per byte.
- Replaces ad-hoc per-state UART polling in the top-level FSM.

Parameters:
- TX_DEPTH, 4, TX buffer entries; power of two, at least 2.
- PTR_W, $clog2(TX_DEPTH), TX buffer pointer width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- rx_en  in  1  loader wants RX bytes; RX is polled only while high
- rx_valid  out  1  rx_data holds an unconsumed byte
- rx_data  out  8  received byte
- rx_ready  in  1  consumer accepts; transfer when rx_valid&rx_ready
- tx_valid  in  1  CPU offers a byte
- tx_data  in  8  byte to send
- tx_ready  out  1  buffer not full; transfer when tx_valid&tx_ready
- tx_idle  out  1  buffer empty and FSM in IDLE
- err  out  1  sticky; set on any nonzero rresp/bresp
- uart_axi_araddr/arvalid out 4/1; arready in 1
- uart_axi_rready out 1; rdata in 32; rresp in 2; rvalid in 1
- uart_axi_awaddr/awvalid out 4/1; awready in 1
- uart_axi_wdata out 32; wstrb out 4; wvalid out 1; wready in 1
- uart_axi_bready out 1; bresp in 2; bvalid in 1

Behaviour:
- Clock and reset: one clock clk; reset rstn is asynchronous, active-low.
- Reset values: all valid/ready outputs 0 (tx_ready and tx_idle become 1 the first cycle after reset); araddr=STAT_REG(8); awaddr=TX_FIFO(4); wdata=0; wstrb=4'b0001; err=0; TX buffer empty; rx holding empty; last_grant=TX.
- Reset mid-transaction: abandons the AXI handshake and drops buffered bytes. This is legal only because the UART is reset together with the block.
- FSM states: IDLE, STAT_AR, STAT_R, RX_AR, RX_R, TX_W, TX_B.
- IDLE:
  - Go to STAT_AR if (rx_en & !rx_valid) or TX buffer non-empty.
  - The decision uses registered state only.
- STAT_AR: araddr=8, arvalid=1; hold until arready, then go to STAT_R.
- STAT_R: rready=1; on rvalid, latch stat=rdata[7:0].
  - rx_ok = rx_en & !rx_valid & stat[0].
  - tx_ok = buffer non-empty & !stat[3].
  - Only rx_ok: go to RX_AR.
  - Only tx_ok: go to TX_W.
  - Both: grant the opposite of last_grant; update last_grant on each grant.
  - Neither: go to IDLE.
- RX_AR: araddr=0, arvalid until arready, then go to RX_R.
- RX_R: rready=1; on rvalid, rx_data=rdata[7:0], rx_valid=1; go to IDLE.
- rx_valid clears on rx_ready. A new RX read never starts while rx_valid=1, so the holding register cannot overflow.
- TX_W:
  - awvalid and wvalid rise together in the first cycle; wdata={24'b0, head byte}.
  - Each valid drops independently on its own ready, including same-cycle readiness.
  - When both handshakes are done, pop the buffer head and go to TX_B.
- TX_B: bready=1; on bvalid, go to IDLE.
- Minimum latencies with slaves always ready:
  - status poll: 2 cycles.
  - RX byte: rx_valid rises 5 cycles after leaving IDLE.
  - TX byte: 5 cycles per byte including the poll.
- Response errors: rresp!=0 or bresp!=0 sets err (cleared only by reset). The transaction still completes; an RX data error still delivers the byte.
- TX buffer:
  - Circular, with PTR_W+1-bit pointers; the extra bit is the wrap flag.
  - full when the low bits are equal and the wrap bits differ.
  - Simultaneous push and pop when full: pop is internal, push is blocked by tx_ready=0 that cycle. No bypass.
  - Push when empty: the byte becomes visible to IDLE the next cycle.
- rx_en dropping mid-RX-read: the read completes and the byte is still presented.

Decomposition:
- Shared package uart_pkg:
  - raddr_type (RX_FIFO=4'h0, STAT_REG=4'h8).
  - waddr_type (TX_FIFO=4'h4, CTRL_REG=4'hC).
  - STAT bit localparams STAT_RX_VALID=0, STAT_TX_FULL=3.
  - arb_state_type enum.
- One sub-module: sync_fifo (width 8, depth TX_DEPTH) holding the TX buffer.

Test Plan:
- Reset then idle, rx_en=0, no tx → zero AXI valids for 100 cycles; tx_ready=1, tx_idle=1.
- rx_en=1; slave status returns 0x01, RX_FIFO returns 0x5A; rx_ready=0 → rx_valid=1, rx_data=0x5A, and no further araddr=0 reads until rx_ready is pulsed.
- Push 0x41,0x42,0x43,0x44 back-to-back → tx_ready=0 after the 4th push. The slave sees wdata 0x41..0x44 in order with wstrb=0001, awaddr=4; tx_idle=1 at the end.
- Status 0x08 (TX full) for 3 polls, then 0x00 → no write during the full polls; exactly one write of the pending byte afterwards.
- rx_en=1, one TX byte pending, status 0x01 → the first grant is RX (last_grant=TX after reset), the next is TX; RX and TX alternate while both stay eligible.
- awready delayed 3 cycles after wready, and bresp=2'b10 → wvalid drops first, awvalid holds until awready; err=1 and stays 1 after the transfer completes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared register map, status bit positions and arbiter state encoding for
// the UART Lite sequencer.
package uart_pkg;

    typedef enum logic [3:0] {
        RX_FIFO  = 4'h0,
        STAT_REG = 4'h8
    } raddr_type;

    typedef enum logic [3:0] {
        TX_FIFO  = 4'h4,
        CTRL_REG = 4'hC
    } waddr_type;

    localparam int STAT_RX_VALID = 0;
    localparam int STAT_TX_FULL  = 3;

    localparam logic [3:0] WSTRB_BYTE0 = 4'b0001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STAT_AR,
        ST_STAT_R,
        ST_RX_AR,
        ST_RX_R,
        ST_TX_W,
        ST_TX_B
    } arb_state_type;

    typedef enum logic {
        GRANT_RX = 1'b0,
        GRANT_TX = 1'b1
    } grant_type;

endpackage

// File: rtl/sync_fifo.sv
// Small circular buffer with wrap-bit pointers; head is readable without a
// pop so the consumer can present it and retire it later.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q;
    logic [PTR_W:0]   rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                     (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_arbiter.sv
// Shares one AXI4-lite UART Lite slave between the RX byte consumer and a
// buffered TX byte producer, polling STAT_REG before every data access.
module uart_arbiter
    import uart_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int PTR_W    = $clog2(TX_DEPTH)
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_en,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        tx_idle,
    output logic        err,
    output logic [3:0]  uart_axi_araddr,
    output logic        uart_axi_arvalid,
    input  logic        uart_axi_arready,
    output logic        uart_axi_rready,
    input  logic [31:0] uart_axi_rdata,
    input  logic [1:0]  uart_axi_rresp,
    input  logic        uart_axi_rvalid,
    output logic [3:0]  uart_axi_awaddr,
    output logic        uart_axi_awvalid,
    input  logic        uart_axi_awready,
    output logic [31:0] uart_axi_wdata,
    output logic [3:0]  uart_axi_wstrb,
    output logic        uart_axi_wvalid,
    input  logic        uart_axi_wready,
    output logic        uart_axi_bready,
    input  logic [1:0]  uart_axi_bresp,
    input  logic        uart_axi_bvalid
);

    arb_state_type state_q;
    arb_state_type state_d;
    grant_type     last_grant_q;
    grant_type     last_grant_d;
    logic          rx_valid_q;
    logic          rx_valid_d;
    logic [7:0]    rx_data_q;
    logic [7:0]    rx_data_d;
    logic [31:0]   wdata_q;
    logic [31:0]   wdata_d;
    logic          aw_done_q;
    logic          aw_done_d;
    logic          w_done_q;
    logic          w_done_d;
    logic          err_q;
    logic          err_d;
    logic          live_q;

    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_head;
    logic          fifo_empty;
    logic          fifo_full;

    logic          r_hs;
    logic          b_hs;
    logic          rx_ok;
    logic          tx_ok;
    logic          aw_now;
    logic          w_now;
    logic          unused_rdata;

    assign unused_rdata = ^uart_axi_rdata[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH),
        .PTR_W (PTR_W)
    ) u_tx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (fifo_push),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign fifo_push = tx_valid & tx_ready;

    assign r_hs  = uart_axi_rvalid & uart_axi_rready;
    assign b_hs  = uart_axi_bvalid & uart_axi_bready;
    assign rx_ok = rx_en & ~rx_valid_q & uart_axi_rdata[STAT_RX_VALID];
    assign tx_ok = ~fifo_empty & ~uart_axi_rdata[STAT_TX_FULL];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rx_valid_d   = rx_valid_q;
        rx_data_d    = rx_data_q;
        wdata_d      = wdata_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        err_d        = err_q;
        fifo_pop     = 1'b0;
        aw_now       = aw_done_q | uart_axi_awready;
        w_now        = w_done_q | uart_axi_wready;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if ((r_hs && (uart_axi_rresp != 2'b00)) || (b_hs && (uart_axi_bresp != 2'b00))) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if ((rx_en && !rx_valid_q) || !fifo_empty) begin
                    state_d = ST_STAT_AR;
                end
            end
            ST_STAT_AR: begin
                if (uart_axi_arready) begin
                    state_d = ST_STAT_R;
                end
            end
            ST_STAT_R: begin
                if (uart_axi_rvalid) begin
                    // With both sides eligible, the side not served last wins.
                    if (rx_ok && (!tx_ok || (last_grant_q == GRANT_TX))) begin
                        state_d      = ST_RX_AR;
                        last_grant_d = GRANT_RX;
                    end else if (tx_ok) begin
                        state_d      = ST_TX_W;
                        last_grant_d = GRANT_TX;
                        wdata_d      = {24'd0, fifo_head};
                        aw_done_d    = 1'b0;
                        w_done_d     = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RX_AR: begin
                if (uart_axi_arready) begin
                    state_d = ST_RX_R;
                end
            end
            ST_RX_R: begin
                if (uart_axi_rvalid) begin
                    rx_data_d  = uart_axi_rdata[7:0];
                    rx_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_TX_W: begin
                aw_done_d = aw_now;
                w_done_d  = w_now;
                if (aw_now && w_now) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_TX_B;
                end
            end
            ST_TX_B: begin
                if (uart_axi_bvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_TX;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= 8'd0;
            wdata_q      <= 32'd0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            err_q        <= 1'b0;
            live_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rx_valid_q   <= rx_valid_d;
            rx_data_q    <= rx_data_d;
            wdata_q      <= wdata_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            err_q        <= err_d;
            live_q       <= 1'b1;
        end
    end

    // live_q keeps tx_ready/tx_idle low while reset is asserted.
    assign tx_ready = live_q & ~fifo_full;
    assign tx_idle  = live_q & fifo_empty & (state_q == ST_IDLE);
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign err      = err_q;

    assign uart_axi_araddr  = (state_q == ST_RX_AR) ? RX_FIFO : STAT_REG;
    assign uart_axi_arvalid = (state_q == ST_STAT_AR) || (state_q == ST_RX_AR);
    assign uart_axi_rready  = (state_q == ST_STAT_R) || (state_q == ST_RX_R);
    assign uart_axi_awaddr  = TX_FIFO;
    assign uart_axi_awvalid = (state_q == ST_TX_W) && !aw_done_q;
    assign uart_axi_wdata   = wdata_q;
    assign uart_axi_wstrb   = WSTRB_BYTE0;
    assign uart_axi_wvalid  = (state_q == ST_TX_W) && !w_done_q;
    assign uart_axi_bready  = (state_q == ST_TX_B);

endmodule

// File: tb/tb_uart_arbiter.sv
// Bench for uart_arbiter: behavioural AXI-lite UART slave plus an event-level
// model of polling, arbitration order and byte streams.
module tb_uart_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx_en = 1'b0;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'd0;
    logic        tx_ready;
    logic        tx_idle;
    logic        err;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bready;
    logic [1:0]  bresp;
    logic        bvalid;

    always #5 clk = ~clk;

    uart_arbiter #(.TX_DEPTH(4)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .rx_en            (rx_en),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .rx_ready         (rx_ready),
        .tx_valid         (tx_valid),
        .tx_data          (tx_data),
        .tx_ready         (tx_ready),
        .tx_idle          (tx_idle),
        .err              (err),
        .uart_axi_araddr  (araddr),
        .uart_axi_arvalid (arvalid),
        .uart_axi_arready (arready),
        .uart_axi_rready  (rready),
        .uart_axi_rdata   (rdata),
        .uart_axi_rresp   (rresp),
        .uart_axi_rvalid  (rvalid),
        .uart_axi_awaddr  (awaddr),
        .uart_axi_awvalid (awvalid),
        .uart_axi_awready (awready),
        .uart_axi_wdata   (wdata),
        .uart_axi_wstrb   (wstrb),
        .uart_axi_wvalid  (wvalid),
        .uart_axi_wready  (wready),
        .uart_axi_bready  (bready),
        .uart_axi_bresp   (bresp),
        .uart_axi_bvalid  (bvalid)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave knobs and observation logs.
    int         ar_delay = 0;
    int         aw_delay = 0;
    int         w_delay = 0;
    logic [1:0] rresp_val = 2'b00;
    logic [1:0] bresp_val = 2'b00;
    logic [7:0] stat_default = 8'h00;
    logic [7:0] stat_seq[$];
    logic [7:0] rx_src[$];
    int         rx_idx = 0;
    logic [7:0] ev_log[$];
    logic [7:0] wr_data_log[$];
    logic [3:0] wr_addr_log[$];
    logic [3:0] wr_strb_log[$];
    int         wr_time_log[$];
    logic [7:0] got_rx[$];
    int         valid_cycles = 0;
    int         aw_only_cycles = 0;
    int         w_only_cycles = 0;

    // AXI-lite slave and monitors; acts on the falling edge so every input
    // it drives is stable at the next rising edge.
    initial begin
        bit          ar_pend, r_pend, aw_pend, w_pend, aw_seen, w_seen, b_pend;
        logic [3:0]  ar_addr_lat;
        logic [31:0] rnd;
        logic [7:0]  byte_v;
        int          ar_cnt, aw_cnt, w_cnt;
        ar_pend = 0; r_pend = 0; aw_pend = 0; w_pend = 0;
        aw_seen = 0; w_seen = 0; b_pend = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; ar_addr_lat = 4'd0;
        arready = 0; rvalid = 0; rdata = 32'd0; rresp = 2'b00;
        awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                ar_pend = 0; r_pend = 0; aw_pend = 0; w_pend = 0;
                aw_seen = 0; w_seen = 0; b_pend = 0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
            end else begin
                if (r_pend) begin rvalid = 0; r_pend = 0; end
                if (b_pend) begin bvalid = 0; b_pend = 0; end
                if (ar_pend) begin
                    ar_pend = 0;
                    rnd = $urandom();
                    if (ar_addr_lat == 4'h8) begin
                        if (stat_seq.size() > 0) byte_v = stat_seq.pop_front();
                        else byte_v = stat_default;
                        ev_log.push_back("S");
                    end else begin
                        if (rx_idx < rx_src.size()) byte_v = rx_src[rx_idx];
                        else byte_v = 8'hEE;
                        rx_idx++;
                        ev_log.push_back("R");
                    end
                    rdata = {rnd[31:8], byte_v};
                    rresp = rresp_val;
                    rvalid = 1;
                end
                if (aw_pend) begin aw_seen = 1; aw_pend = 0; end
                if (w_pend) begin w_seen = 1; w_pend = 0; end
                if (aw_seen && w_seen) begin
                    aw_seen = 0; w_seen = 0;
                    bvalid = 1; bresp = bresp_val;
                end

                arready = arvalid && (ar_cnt >= ar_delay);
                if (arvalid && !arready) ar_cnt++;
                if (arvalid && arready) begin ar_pend = 1; ar_addr_lat = araddr; ar_cnt = 0; end
                if (rvalid && rready) r_pend = 1;

                awready = awvalid && (aw_cnt >= aw_delay);
                if (awvalid && !awready) aw_cnt++;
                if (awvalid && awready) begin
                    aw_pend = 1; aw_cnt = 0;
                    wr_addr_log.push_back(awaddr);
                end
                wready = wvalid && (w_cnt >= w_delay);
                if (wvalid && !wready) w_cnt++;
                if (wvalid && wready) begin
                    w_pend = 1; w_cnt = 0;
                    wr_data_log.push_back(wdata[7:0]);
                    wr_strb_log.push_back(wstrb);
                    wr_time_log.push_back(cyc);
                    ev_log.push_back("W");
                    $display("[%0t] axi write wdata=%08h wstrb=%b awaddr=%h", $time, wdata, wstrb, awaddr);
                end
                if (bvalid && bready) b_pend = 1;

                if (arvalid || awvalid || wvalid) valid_cycles++;
                if (awvalid && !wvalid) aw_only_cycles++;
                if (wvalid && !awvalid) w_only_cycles++;
                if (rx_valid && rx_ready) begin
                    got_rx.push_back(rx_data);
                    $display("[%0t] rx byte delivered data=%02h", $time, rx_data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        rx_en = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'd0;
        ar_delay = 0; aw_delay = 0; w_delay = 0;
        rresp_val = 2'b00; bresp_val = 2'b00;
        stat_default = 8'h00;
        stat_seq.delete();
        rx_src.delete();
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        rx_idx = 0;
        ev_log.delete(); wr_data_log.delete(); wr_addr_log.delete();
        wr_strb_log.delete(); wr_time_log.delete(); got_rx.delete();
        valid_cycles = 0; aw_only_cycles = 0; w_only_cycles = 0;
    endtask

    task automatic wait_tx_idle(input int limit, input string name);
        int n = 0;
        while (!tx_idle && n < limit) begin tick(); n++; end
        checks++;
        if (!tx_idle) begin
            errors++;
            $display("FAIL %s timeout: tx_idle=%0b after %0d cycles, required 1", name, tx_idle, n);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) tick();
        checks++;
        if (tx_ready !== 1'b0 || tx_idle !== 1'b0 || rx_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: tx_ready=%b tx_idle=%b rx_valid=%b err=%b, required 0 0 0 0",
                     tx_ready, tx_idle, rx_valid, err);
        end
        checks++;
        if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_axi_valids: ar/r/aw/w/b=%b, required 00000",
                     {arvalid, rready, awvalid, wvalid, bready});
        end
        checks++;
        if (araddr !== 4'h8 || awaddr !== 4'h4 || wdata !== 32'd0 || wstrb !== 4'b0001) begin
            errors++;
            $display("FAIL reset_axi_fields: araddr=%h awaddr=%h wdata=%h wstrb=%b, required 8 4 0 0001",
                     araddr, awaddr, wdata, wstrb);
        end
        rstn = 1'b1;
        tick();
        checks++;
        if (tx_ready !== 1'b1 || tx_idle !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: tx_ready=%b tx_idle=%b, required 1 1", tx_ready, tx_idle);
        end
        valid_cycles = 0;
        ev_log.delete();
        repeat (100) tick();
        checks++;
        if (valid_cycles != 0 || ev_log.size() != 0) begin
            errors++;
            $display("FAIL idle_quiet: valid_cycles=%0d transactions=%0d, required 0 0",
                     valid_cycles, ev_log.size());
        end
        checks++;
        if (tx_ready !== 1'b1 || tx_idle !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: tx_ready=%b tx_idle=%b, required 1 1", tx_ready, tx_idle);
        end
    endtask

    task automatic test_rx_hold();
        int n = 0;
        do_reset();
        stat_default = 8'h01;
        rx_src.push_back(8'h5A);
        rx_en = 1'b1;
        while (!rx_valid && n < 50) begin tick(); n++; end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL rx_latency: rx_valid after %0d cycles, required 5", n);
        end
        checks++;
        if (rx_data !== 8'h5A) begin
            errors++;
            $display("FAIL rx_data: got %02h, required 5a", rx_data);
        end
        repeat (40) tick();
        checks++;
        if (ev_log.size() != 2 || ev_log[0] != "S" || ev_log[1] != "R" || rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL rx_hold_no_reread: transactions=%0d rx_valid=%b, required 2 (status,rx) and 1",
                     ev_log.size(), rx_valid);
        end
        rx_en = 1'b0;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        checks++;
        if (rx_valid !== 1'b0 || got_rx.size() != 1) begin
            errors++;
            $display("FAIL rx_consume: rx_valid=%b delivered=%0d, required 0 1", rx_valid, got_rx.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[4];
        bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43; bytes[3] = 8'h44;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx_ready !== 1'b1) begin
                errors++;
                $display("FAIL push_ready_%0d: tx_ready=%b, required 1", i, tx_ready);
            end
            tx_valid = 1'b1;
            tx_data = bytes[i];
            tick();
        end
        tx_valid = 1'b0;
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_after_4: tx_ready=%b, required 0", tx_ready);
        end
        wait_tx_idle(200, "b2b_drain");
        checks++;
        if (wr_data_log.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: writes=%0d, required 4", wr_data_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_data_log[i] !== bytes[i] || wr_addr_log[i] !== 4'h4 || wr_strb_log[i] !== 4'b0001) begin
                    errors++;
                    $display("FAIL b2b_write_%0d: wdata=%02h awaddr=%h wstrb=%b, required %02h 4 0001",
                             i, wr_data_log[i], wr_addr_log[i], wr_strb_log[i], bytes[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (wr_time_log[i] - wr_time_log[i-1] != 5) begin
                    errors++;
                    $display("FAIL b2b_spacing_%0d: %0d cycles, required 5",
                             i, wr_time_log[i] - wr_time_log[i-1]);
                end
            end
        end
        checks++;
        if (tx_idle !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: tx_idle=%b err=%b, required 1 0", tx_idle, err);
        end
    endtask

    task automatic test_tx_full_polls();
        logic [7:0] b;
        logic [7:0] exp_log[$];
        bit ok;
        do_reset();
        b = 8'($urandom_range(0, 255));
        stat_seq.push_back(8'h08); stat_seq.push_back(8'h08); stat_seq.push_back(8'h08);
        for (int i = 0; i < 4; i++) exp_log.push_back("S");
        exp_log.push_back("W");
        tx_valid = 1'b1; tx_data = b;
        tick();
        tx_valid = 1'b0;
        wait_tx_idle(200, "full_polls_drain");
        ok = (ev_log.size() == exp_log.size());
        for (int i = 0; i < exp_log.size() && ok; i++) if (ev_log[i] != exp_log[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL full_polls_order: %0d transactions, required 4 status polls then 1 write",
                     ev_log.size());
        end
        checks++;
        if (wr_data_log.size() != 1 || wr_data_log[0] !== b) begin
            errors++;
            $display("FAIL full_polls_data: writes=%0d, required one write of %02h", wr_data_log.size(), b);
        end
    endtask

    task automatic test_arbitration();
        logic [7:0] tx_bytes[3];
        logic [7:0] exp_log[$];
        int tx_left = 3;
        bit last_tx = 1;
        int n = 0;
        int r_count = 0;
        bit ok;
        do_reset();
        stat_default = 8'h01;
        for (int i = 0; i < 16; i++) rx_src.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < 3; i++) tx_bytes[i] = 8'($urandom_range(0, 255));
        // Model: RX is always eligible; alternate while TX is also eligible.
        while (exp_log.size() < 12) begin
            exp_log.push_back("S");
            if (tx_left > 0 && last_tx) begin exp_log.push_back("R"); last_tx = 0; end
            else if (tx_left > 0) begin exp_log.push_back("W"); tx_left--; last_tx = 1; end
            else begin exp_log.push_back("R"); last_tx = 0; end
        end
        rx_ready = 1'b1;
        rx_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_valid = 1'b1; tx_data = tx_bytes[i];
            tick();
        end
        tx_valid = 1'b0;
        while (ev_log.size() < 12 && n < 400) begin tick(); n++; end
        rx_en = 1'b0;
        n = 0;
        while (!(tx_idle && !rx_valid) && n < 100) begin tick(); n++; end
        repeat (5) tick();
        ok = (ev_log.size() >= 12);
        for (int i = 0; i < 12 && ok; i++) if (ev_log[i] != exp_log[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL arb_order: transactions=%0d, first 12 do not alternate RX,TX starting with RX",
                     ev_log.size());
        end
        checks++;
        if (wr_data_log.size() != 3) begin
            errors++;
            $display("FAIL arb_tx_count: writes=%0d, required 3", wr_data_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_data_log[i] !== tx_bytes[i]) begin
                    errors++;
                    $display("FAIL arb_tx_%0d: wdata=%02h, required %02h", i, wr_data_log[i], tx_bytes[i]);
                end
            end
        end
        foreach (ev_log[i]) if (ev_log[i] == "R") r_count++;
        checks++;
        if (got_rx.size() != r_count) begin
            errors++;
            $display("FAIL arb_rx_count: delivered=%0d, required %0d", got_rx.size(), r_count);
        end else begin
            ok = 1;
            for (int i = 0; i < r_count; i++) if (got_rx[i] !== rx_src[i]) ok = 0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL arb_rx_data: delivered stream differs from slave RX_FIFO order (%0d bytes)",
                         r_count);
            end
        end
    endtask

    task automatic test_write_err();
        logic [7:0] b;
        do_reset();
        b = 8'($urandom_range(0, 255));
        aw_delay = 3;
        bresp_val = 2'b10;
        tx_valid = 1'b1; tx_data = b;
        tick();
        tx_valid = 1'b0;
        wait_tx_idle(200, "werr_drain");
        checks++;
        if (aw_only_cycles != 3 || w_only_cycles != 0) begin
            errors++;
            $display("FAIL werr_valid_split: awvalid-only=%0d wvalid-only=%0d, required 3 0",
                     aw_only_cycles, w_only_cycles);
        end
        checks++;
        if (err !== 1'b1 || wr_data_log.size() != 1 || wr_data_log[0] !== b) begin
            errors++;
            $display("FAIL werr_done: err=%b writes=%0d, required err 1 and one write of %02h",
                     err, wr_data_log.size(), b);
        end
        repeat (10) tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL werr_sticky: err=%b, required 1", err);
        end
    endtask

    task automatic test_rx_err();
        logic [7:0] b;
        int n = 0;
        do_reset();
        b = 8'($urandom_range(0, 255));
        stat_default = 8'h01;
        rx_src.push_back(b);
        rresp_val = 2'b10;
        rx_en = 1'b1;
        while (!rx_valid && n < 50) begin tick(); n++; end
        rx_en = 1'b0;
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== b || err !== 1'b1) begin
            errors++;
            $display("FAIL rerr: rx_valid=%b rx_data=%02h err=%b, required 1 %02h 1", rx_valid, rx_data, err, b);
        end
    endtask

    initial begin
        test_reset();
        test_rx_hold();
        test_back_to_back();
        test_tx_full_polls();
        test_arbitration();
        test_write_err();
        test_rx_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
